// File: rtl/branch_predict_flush_ctrl.sv
// rtl/branch_predict_flush_ctrl.sv - branch prediction, redirect and flush control with a 2-bit BHT
//
// Resolves JMP/JAL/JALR in EX against a prediction made in ID. In ID, a JAL is predicted taken and a JMP is
// predicted from a 2-bit counter BHT. The block issues ID redirects for predicted-taken ops and EX redirects on
// mispredict, drives the IF/ID and ID/EX flushes, and keeps saturating branch and mispredict counters.
//
// Parameters
//   MODE           0 = static not-taken, 1 = dynamic BHT
//   BHT_ENTRIES    BHT depth, power of two, >= 2
//   PC_W           PC / target width
//   CNT_W          performance counter width
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   stall           pipeline hold; gates BHT updates and counter increments
//   ID_valid/pc/npc_op/target       instruction in ID
//   ID_pred_taken, ID_redirect      prediction for ID, early redirect to ID_target
//   EX_valid/pc/npc_op/f/target/jalr_target/pred_taken   instruction resolving in EX
//   EX_redirect, EX_redirect_pc     mispredict redirect and corrected PC
//   flush_if_id, flush_id_ex        pipeline register kills
//   ready           0 while the BHT initialises
//   branch_cnt, mispredict_cnt      saturating performance counters

module branch_predict_flush_ctrl #(
   parameter int MODE        = 1,
   parameter int BHT_ENTRIES = 64,
   parameter int PC_W        = 32,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             ID_valid,
   input  logic [PC_W-1:0]  ID_pc,
   input  logic [1:0]       ID_npc_op,
   input  logic [PC_W-1:0]  ID_target,
   output logic             ID_pred_taken,
   output logic             ID_redirect,
   input  logic             EX_valid,
   input  logic [PC_W-1:0]  EX_pc,
   input  logic [1:0]       EX_npc_op,
   input  logic             EX_f,
   input  logic [PC_W-1:0]  EX_target,
   input  logic [PC_W-1:0]  EX_jalr_target,
   input  logic             EX_pred_taken,
   output logic             EX_redirect,
   output logic [PC_W-1:0]  EX_redirect_pc,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             ready,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(BHT_ENTRIES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   // Next-PC op encodings
   localparam logic [1:0] NPC_PC4  = 2'b00;
   localparam logic [1:0] NPC_JMP  = 2'b01;
   localparam logic [1:0] NPC_JAL  = 2'b10;
   localparam logic [1:0] NPC_JALR = 2'b11;

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] init_idx;
   logic [IDX_W-1:0] id_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [1:0]       bht_id_rd;
   logic [1:0]       bht_ex_rd;
   logic [1:0]       bht_ex_nxt;
   logic             run;
   logic             ex_taken;
   logic             upd_en;
   logic             unused_id;

   // ID_target goes straight to the fetch mux; only the index bits of ID_pc matter here
   assign unused_id = ^{ID_target, ID_pc};

   assign id_idx = ID_pc[IDX_W+1:2];
   assign ex_idx = EX_pc[IDX_W+1:2];
   assign run    = (state == ST_RUN);
   assign upd_en = run & EX_valid & ~stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_INIT;
         init_idx <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT) begin
            init_idx <= init_idx + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         ST_INIT: begin
            if ((MODE == 0) || (init_idx == INIT_LAST)) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            ready = 1'b1;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   // Saturating 2-bit step for the entry of the JMP resolving in EX
   always_comb begin
      bht_ex_nxt = bht_ex_rd;
      if (EX_f) begin
         if (bht_ex_rd != 2'b11) bht_ex_nxt = bht_ex_rd + 2'b01;
      end else begin
         if (bht_ex_rd != 2'b00) bht_ex_nxt = bht_ex_rd - 2'b01;
      end
   end

   generate
      if (MODE != 0) begin : g_bht
         logic [1:0] bht [BHT_ENTRIES];

         // Reads are combinational and see the pre-edge contents, so a same-cycle
         // update to the ID index is not forwarded.
         always_ff @(posedge clk) begin
            if (state == ST_INIT) begin
               bht[init_idx] <= 2'b01;
            end else if (upd_en && (EX_npc_op == NPC_JMP)) begin
               bht[ex_idx] <= bht_ex_nxt;
            end
         end

         assign bht_id_rd = bht[id_idx];
         assign bht_ex_rd = bht[ex_idx];
      end else begin : g_no_bht
         assign bht_id_rd = 2'b01;
         assign bht_ex_rd = 2'b01;
      end
   endgenerate

   always_comb begin
      ex_taken = 1'b0;
      case (EX_npc_op)
         NPC_JMP:           ex_taken = EX_f;
         NPC_JAL, NPC_JALR: ex_taken = 1'b1;
         default:           ex_taken = 1'b0;
      endcase
   end

   // JALR targets are never predicted, so a JALR always redirects
   assign EX_redirect = EX_valid & ((ex_taken != EX_pred_taken) | (EX_npc_op == NPC_JALR));

   always_comb begin
      EX_redirect_pc = EX_pc + PC_W'(4);
      if (EX_npc_op == NPC_JALR) begin
         EX_redirect_pc = EX_jalr_target;
      end else if (ex_taken) begin
         EX_redirect_pc = EX_target;
      end
   end

   always_comb begin
      ID_pred_taken = 1'b0;
      if (run && (MODE != 0) && ID_valid) begin
         case (ID_npc_op)
            NPC_JAL: ID_pred_taken = 1'b1;
            NPC_JMP: ID_pred_taken = bht_id_rd[1];
            NPC_PC4: ID_pred_taken = 1'b0;
            default: ID_pred_taken = 1'b0;
         endcase
      end
   end

   // An older EX redirect wins; the ID instruction is flushed anyway
   assign ID_redirect = ID_pred_taken & ~stall & ~EX_redirect;
   assign flush_if_id = EX_redirect | ID_redirect;
   assign flush_id_ex = EX_redirect;

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else if (run && !stall) begin
         if (EX_valid && (EX_npc_op == NPC_JMP) && (branch_cnt != CNT_MAX)) begin
            branch_cnt <= branch_cnt + 1'b1;
         end
         if (EX_redirect && (mispredict_cnt != CNT_MAX)) begin
            mispredict_cnt <= mispredict_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predict_flush_ctrl.sv
// tb/tb_branch_predict_flush_ctrl.sv - scoreboard bench for branch_predict_flush_ctrl

module tb_branch_predict_flush_ctrl;

   localparam int PC_W  = 32;
   localparam int CNT_W = 4;
   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_JMP  = 2'b01;
   localparam logic [1:0] OP_JAL  = 2'b10;
   localparam logic [1:0] OP_JALR = 2'b11;

   localparam int S_IDPT = 0, S_IDR = 1, S_EXR = 2, S_RPC = 3, S_FIF = 4, S_FIE = 5,
                  S_READY = 6, S_BCNT = 7, S_MCNT = 8,
                  S0_IDPT = 10, S0_EXR = 12, S0_RPC = 13, S0_FIE = 15, S0_READY = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic stall = 1'b0;
   logic id_valid = 1'b0;
   logic [PC_W-1:0] id_pc = '0;
   logic [1:0] id_op = OP_NONE;
   logic [PC_W-1:0] id_tgt = '0;
   logic ex_valid = 1'b0;
   logic [PC_W-1:0] ex_pc = '0;
   logic [1:0] ex_op = OP_NONE;
   logic ex_f = 1'b0;
   logic [PC_W-1:0] ex_tgt = '0;
   logic [PC_W-1:0] ex_jt = '0;
   logic ex_pred = 1'b0;

   logic id_pt, id_r, ex_r, fif, fie, rdy;
   logic [PC_W-1:0] rpc;
   logic [CNT_W-1:0] bcnt, mcnt;
   logic id_pt0, id_r0, ex_r0, fif0, fie0, rdy0;
   logic [PC_W-1:0] rpc0;
   logic [CNT_W-1:0] bcnt0, mcnt0;

   always #5 clk = ~clk;

   branch_predict_flush_ctrl #(.MODE(1), .BHT_ENTRIES(64), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .ID_valid(id_valid), .ID_pc(id_pc), .ID_npc_op(id_op), .ID_target(id_tgt),
      .ID_pred_taken(id_pt), .ID_redirect(id_r),
      .EX_valid(ex_valid), .EX_pc(ex_pc), .EX_npc_op(ex_op), .EX_f(ex_f), .EX_target(ex_tgt),
      .EX_jalr_target(ex_jt), .EX_pred_taken(ex_pred),
      .EX_redirect(ex_r), .EX_redirect_pc(rpc), .flush_if_id(fif), .flush_id_ex(fie),
      .ready(rdy), .branch_cnt(bcnt), .mispredict_cnt(mcnt)
   );

   branch_predict_flush_ctrl #(.MODE(0), .BHT_ENTRIES(64), .PC_W(PC_W), .CNT_W(CNT_W)) dut0 (
      .clk(clk), .rst(rst), .stall(stall),
      .ID_valid(id_valid), .ID_pc(id_pc), .ID_npc_op(id_op), .ID_target(id_tgt),
      .ID_pred_taken(id_pt0), .ID_redirect(id_r0),
      .EX_valid(ex_valid), .EX_pc(ex_pc), .EX_npc_op(ex_op), .EX_f(ex_f), .EX_target(ex_tgt),
      .EX_jalr_target(ex_jt), .EX_pred_taken(ex_pred),
      .EX_redirect(ex_r0), .EX_redirect_pc(rpc0), .flush_if_id(fif0), .flush_id_ex(fie0),
      .ready(rdy0), .branch_cnt(bcnt0), .mispredict_cnt(mcnt0)
   );

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_mis = 0;

   logic [1:0] m_bht [64];
   int m_br = 0;
   int m_mc = 0;
   int m_init = 0;
   bit m_ready = 1'b0;
   bit m_ready0 = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int sel, input logic [31:0] exp, input string tag);
      exp_t e;
      e.sel = sel;
      e.exp = exp;
      e.tag = tag;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] get_sig(input int sel);
      case (sel)
         S_IDPT:   return 32'(id_pt);
         S_IDR:    return 32'(id_r);
         S_EXR:    return 32'(ex_r);
         S_RPC:    return rpc;
         S_FIF:    return 32'(fif);
         S_FIE:    return 32'(fie);
         S_READY:  return 32'(rdy);
         S_BCNT:   return 32'(bcnt);
         S_MCNT:   return 32'(mcnt);
         S0_IDPT:  return 32'(id_pt0);
         S0_EXR:   return 32'(ex_r0);
         S0_RPC:   return rpc0;
         S0_FIE:   return 32'(fie0);
         S0_READY: return 32'(rdy0);
         default:  return 32'hdead_beef;
      endcase
   endfunction

   function automatic int idx(input logic [PC_W-1:0] pc);
      return int'(pc[7:2]);
   endfunction

   function automatic logic m_taken();
      if (ex_op == OP_JMP) return ex_f;
      return (ex_op == OP_JAL) || (ex_op == OP_JALR);
   endfunction

   function automatic logic m_exr();
      return ex_valid && ((m_taken() != ex_pred) || (ex_op == OP_JALR));
   endfunction

   // Expected combinational outputs of the MODE=1 instance for the inputs now driven
   task automatic expect_now();
      logic pt, er, ir;
      logic [31:0] epc;
      pt = 1'b0;
      if (m_ready && id_valid) begin
         if (id_op == OP_JAL) pt = 1'b1;
         else if (id_op == OP_JMP) pt = m_bht[idx(id_pc)][1];
      end
      er = m_exr();
      if (ex_op == OP_JALR) epc = ex_jt;
      else if (m_taken()) epc = ex_tgt;
      else epc = ex_pc + 32'd4;
      ir = pt & ~stall & ~er;
      push(S_IDPT, 32'(pt), "id_pred_taken");
      push(S_IDR, 32'(ir), "id_redirect");
      push(S_EXR, 32'(er), "ex_redirect");
      if (er) push(S_RPC, epc, "ex_redirect_pc");
      push(S_FIF, 32'(er | ir), "flush_if_id");
      push(S_FIE, 32'(er), "flush_id_ex");
      push(S_READY, 32'(m_ready), "ready");
      push(S_BCNT, 32'(m_br), "branch_cnt");
      push(S_MCNT, 32'(m_mc), "mispredict_cnt");
   endtask

   task automatic model_edge();
      if (rst) begin
         m_br = 0;
         m_mc = 0;
         m_init = 0;
         m_ready = 1'b0;
         m_ready0 = 1'b0;
      end else begin
         m_ready0 = 1'b1;
         if (!m_ready) begin
            m_bht[m_init] = 2'b01;
            m_init++;
            if (m_init == 64) m_ready = 1'b1;
         end else if (!stall && ex_valid) begin
            if (m_exr() && m_mc < 15) m_mc++;
            if (ex_op == OP_JMP) begin
               if (m_br < 15) m_br++;
               if (ex_f && m_bht[idx(ex_pc)] != 2'b11) m_bht[idx(ex_pc)] = m_bht[idx(ex_pc)] + 2'b01;
               if (!ex_f && m_bht[idx(ex_pc)] != 2'b00) m_bht[idx(ex_pc)] = m_bht[idx(ex_pc)] - 2'b01;
            end
         end
      end
   endtask

   // Compare everything queued on the falling edge, then advance the model and the DUT together
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, get_sig(e.sel), e.exp);
      end
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [1:0] op, input logic [31:0] t);
      id_valid = v; id_pc = pc; id_op = op; id_tgt = t;
   endtask

   task automatic set_ex(input logic v, input logic [31:0] pc, input logic [1:0] op, input logic f,
                         input logic [31:0] t, input logic [31:0] jt, input logic pred);
      ex_valid = v; ex_pc = pc; ex_op = op; ex_f = f; ex_tgt = t; ex_jt = jt; ex_pred = pred;
   endtask

   task automatic idle();
      set_id(1'b0, 32'h0, OP_NONE, 32'h0);
      set_ex(1'b0, 32'h0, OP_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int br_before;
      idle();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;

      // Initialisation: ready low for 64 cycles, high on the 65th
      for (int c = 1; c <= 65; c++) begin
         expect_now();
         push(S_READY, 32'(c == 65), "init_ready");
         if (c == 1) push(S0_READY, 32'd0, "mode0_ready_c1");
         if (c == 2) push(S0_READY, 32'd1, "mode0_ready_c2");
         cycle();
      end

      // Every entry initialised to a not-taken state
      for (int i = 0; i < 64; i++) begin
         set_id(1'b1, 32'(i * 4), OP_JMP, 32'h0);
         expect_now();
         push(S_IDPT, 32'd0, "init_entry");
         cycle();
      end
      idle();

      // Taken JMP predicted not-taken: redirect to target, both flushes, entry 01 -> 10
      set_ex(1'b1, 32'h100, OP_JMP, 1'b1, 32'h180, 32'h0, 1'b0);
      expect_now();
      push(S_EXR, 32'd1, "jmp_mp_redirect");
      push(S_RPC, 32'h180, "jmp_mp_pc");
      push(S_FIF, 32'd1, "jmp_mp_flush_if");
      push(S_FIE, 32'd1, "jmp_mp_flush_ex");
      cycle();
      idle();
      set_id(1'b1, 32'h100, OP_JMP, 32'h180);
      expect_now();
      push(S_IDPT, 32'd1, "bht_10_pred");
      push(S_IDR, 32'd1, "bht_10_id_redirect");
      push(S_FIE, 32'd0, "id_redirect_no_ex_flush");
      push(S_BCNT, 32'd1, "branch_cnt_1");
      push(S_MCNT, 32'd1, "mispredict_cnt_1");
      cycle();
      idle();

      // Drive entry 0 to 11, then four not-taken at 0x200 (same entry) -> 00 and stays
      set_ex(1'b1, 32'h100, OP_JMP, 1'b1, 32'h180, 32'h0, 1'b1);
      expect_now();
      cycle();
      for (int k = 0; k < 4; k++) begin
         set_ex(1'b1, 32'h200, OP_JMP, 1'b0, 32'h280, 32'h0, 1'b1);
         expect_now();
         push(S_RPC, 32'h204, "jmp_nt_pc4");
         cycle();
      end
      idle();
      set_id(1'b1, 32'h200, OP_JMP, 32'h280);
      expect_now();
      push(S_IDPT, 32'd0, "bht_low_pred");
      cycle();
      idle();
      set_ex(1'b1, 32'h200, OP_JMP, 1'b1, 32'h280, 32'h0, 1'b0);
      expect_now();
      cycle();
      idle();
      set_id(1'b1, 32'h200, OP_JMP, 32'h280);
      expect_now();
      push(S_IDPT, 32'd0, "bht_sat_00");
      cycle();
      idle();

      // JALR in EX beats a predicted-taken JAL in ID
      set_id(1'b1, 32'h400, OP_JAL, 32'h500);
      set_ex(1'b1, 32'h420, OP_JALR, 1'b0, 32'h440, 32'h3000, 1'b0);
      expect_now();
      push(S_IDPT, 32'd1, "jal_pred");
      push(S_IDR, 32'd0, "jalr_wins_id_redirect");
      push(S_EXR, 32'd1, "jalr_redirect");
      push(S_RPC, 32'h3000, "jalr_pc");
      push(S0_IDPT, 32'd0, "mode0_no_pred");
      push(S0_EXR, 32'd1, "mode0_jalr_redirect");
      push(S0_RPC, 32'h3000, "mode0_jalr_pc");
      cycle();
      idle();

      // Three stalled cycles then release: one count, one BHT step
      br_before = m_br;
      stall = 1'b1;
      set_ex(1'b1, 32'h108, OP_JMP, 1'b1, 32'h1f0, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         expect_now();
         cycle();
      end
      stall = 1'b0;
      expect_now();
      cycle();
      idle();
      set_id(1'b1, 32'h108, OP_JMP, 32'h1f0);
      expect_now();
      push(S_BCNT, 32'(br_before + 1), "stall_one_count");
      push(S_IDPT, 32'd1, "stall_step_taken");
      cycle();
      idle();
      set_ex(1'b1, 32'h108, OP_JMP, 1'b0, 32'h1f0, 32'h0, 1'b1);
      expect_now();
      cycle();
      idle();
      set_id(1'b1, 32'h108, OP_JMP, 32'h1f0);
      expect_now();
      push(S_IDPT, 32'd0, "stall_single_step");
      cycle();
      idle();

      // Static mode: taken JAL redirects in EX
      set_ex(1'b1, 32'h700, OP_JAL, 1'b0, 32'h7a0, 32'h0, 1'b0);
      expect_now();
      push(S0_EXR, 32'd1, "mode0_jal_redirect");
      push(S0_RPC, 32'h7a0, "mode0_jal_pc");
      push(S0_FIE, 32'd1, "mode0_jal_flush");
      cycle();
      set_ex(1'b1, 32'h700, OP_JAL, 1'b0, 32'h7a0, 32'h0, 1'b1);
      expect_now();
      cycle();

      // Counter saturation
      for (int k = 0; k < 16; k++) begin
         set_ex(1'b1, 32'h600, OP_JALR, 1'b0, 32'h0, 32'(32'h3000 + k * 4), 1'b0);
         expect_now();
         cycle();
      end
      for (int k = 0; k < 10; k++) begin
         set_ex(1'b1, 32'h10c, OP_JMP, 1'b1, 32'h1200, 32'h0, 1'b1);
         expect_now();
         cycle();
      end
      idle();
      expect_now();
      push(S_MCNT, 32'd15, "mispredict_sat");
      push(S_BCNT, 32'd15, "branch_sat");
      cycle();
      set_ex(1'b1, 32'h600, OP_JALR, 1'b0, 32'h0, 32'h3000, 1'b0);
      expect_now();
      cycle();
      idle();
      expect_now();
      push(S_MCNT, 32'd15, "mispredict_stays_sat");
      cycle();

      // Reset in RUN, then again mid-INIT: initialisation restarts from entry 0
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         expect_now();
         cycle();
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      set_id(1'b1, 32'h10c, OP_JMP, 32'h1200);
      for (int c = 1; c <= 65; c++) begin
         expect_now();
         push(S_READY, 32'(c == 65), "reinit_ready");
         if (c == 65) begin
            push(S_IDPT, 32'd0, "reinit_bht");
            push(S_BCNT, 32'd0, "reinit_branch_cnt");
            push(S_MCNT, 32'd0, "reinit_mispredict_cnt");
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
